// File: rtl/i2c_regfile_target.sv
// I2C target exposing a byte register file to an external controller.
// The topmost RO_COUNT registers are read-only and are sourced from status_in.
`timescale 1ns/1ps
module i2c_regfile_target #(
  parameter logic [6:0] DEV_ADDR = 7'h42,
  parameter int         REGCOUNT = 20,
  parameter int         RO_COUNT = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    scl_in,
  input  logic                    sda_in,
  output logic                    sda_oe,
  input  logic [8*RO_COUNT-1:0]   status_in,
  output logic [8*REGCOUNT-1:0]   registers_packed,
  output logic                    wr_strobe,
  output logic [6:0]              wr_addr,
  output logic                    busy
);

  localparam int         RO_BASE    = REGCOUNT - RO_COUNT;
  localparam logic [6:0] LAST_IDX   = 7'(REGCOUNT - 1);
  localparam logic [7:0] REGCOUNT_B = 8'(REGCOUNT);
  localparam logic [7:0] RO_BASE_B  = 8'(RO_BASE);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RDATA_ACK = 4'd8,
    IGNORE    = 4'd9
  } state_t;

  function automatic logic [6:0] next_ptr(input logic [6:0] p);
    return (p == LAST_IDX) ? 7'd0 : p + 7'd1;
  endfunction

  logic [2:0] scl_sync_r;
  logic [2:0] sda_sync_r;
  logic       scl_s;
  logic       sda_s;
  logic       scl_rise_s;
  logic       scl_fall_s;
  logic       start_s;
  logic       stop_s;
  logic       is_ro_s;
  logic [7:0] rd_byte_s;

  state_t     state_r;
  logic [3:0] bit_cnt_r;
  logic [7:0] shift_r;
  logic [7:0] tx_r;
  logic [6:0] ptr_r;
  logic       rw_r;
  logic       ack_r;

  // Pad synchronizers; bit 1 is the synchronized level, bit 2 its delayed copy.
  always_ff @(posedge clock) begin
    if (reset) begin
      scl_sync_r <= 3'b111;
      sda_sync_r <= 3'b111;
    end else begin
      scl_sync_r <= {scl_sync_r[1:0], scl_in};
      sda_sync_r <= {sda_sync_r[1:0], sda_in};
    end
  end

  assign scl_s      = scl_sync_r[1];
  assign sda_s      = sda_sync_r[1];
  assign scl_rise_s = scl_sync_r[1] & ~scl_sync_r[2];
  assign scl_fall_s = ~scl_sync_r[1] & scl_sync_r[2];
  assign start_s    = scl_s & ~sda_sync_r[1] & sda_sync_r[2];
  assign stop_s     = scl_s & sda_sync_r[1] & ~sda_sync_r[2];
  assign is_ro_s    = ({1'b0, ptr_r} >= RO_BASE_B);

  // Read-side mux: writable registers below RO_BASE, status bytes above.
  always_comb begin
    rd_byte_s = 8'h00;
    for (int i = 0; i < RO_BASE; i++) begin
      rd_byte_s = rd_byte_s | ((ptr_r == 7'(i)) ? registers_packed[8*i +: 8] : 8'h00);
    end
    for (int k = 0; k < RO_COUNT; k++) begin
      rd_byte_s = rd_byte_s | ((ptr_r == 7'(RO_BASE + k)) ? status_in[8*k +: 8] : 8'h00);
    end
  end

  // Protocol FSM: START beats STOP beats SCL edges; sda_oe moves on SCL falls.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r          <= IDLE;
      bit_cnt_r        <= 4'd0;
      shift_r          <= 8'h00;
      tx_r             <= 8'h00;
      ptr_r            <= 7'd0;
      rw_r             <= 1'b0;
      ack_r            <= 1'b1;
      sda_oe           <= 1'b0;
      wr_strobe        <= 1'b0;
      wr_addr          <= 7'd0;
      busy             <= 1'b0;
      registers_packed <= {(8*REGCOUNT){1'b0}};
    end else begin
      wr_strobe <= 1'b0;
      if (start_s) begin
        state_r   <= ADDR;
        bit_cnt_r <= 4'd0;
        sda_oe    <= 1'b0;
      end else if (stop_s) begin
        state_r   <= IDLE;
        bit_cnt_r <= 4'd0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else if (scl_rise_s) begin
        case (state_r)
          ADDR, PTR, WDATA: begin
            shift_r   <= {shift_r[6:0], sda_s};
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end
          RDATA:     bit_cnt_r <= bit_cnt_r + 4'd1;
          RDATA_ACK: ack_r     <= sda_s;
          default: ;
        endcase
      end else if (scl_fall_s) begin
        case (state_r)
          ADDR: begin
            if (bit_cnt_r == 4'd8) begin
              if (shift_r[7:1] == DEV_ADDR) begin
                state_r <= ADDR_ACK;
                rw_r    <= shift_r[0];
                sda_oe  <= 1'b1;
                busy    <= 1'b1;
              end else begin
                state_r <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            bit_cnt_r <= 4'd0;
            if (rw_r) begin
              state_r <= RDATA;
              sda_oe  <= ~rd_byte_s[7];
              tx_r    <= {rd_byte_s[6:0], 1'b0};
            end else begin
              state_r <= PTR;
              sda_oe  <= 1'b0;
            end
          end
          PTR: begin
            if (bit_cnt_r == 4'd8) begin
              if (shift_r < REGCOUNT_B) begin
                ptr_r   <= shift_r[6:0];
                sda_oe  <= 1'b1;
                state_r <= PTR_ACK;
              end else begin
                state_r <= IGNORE;
              end
            end
          end
          PTR_ACK: begin
            sda_oe    <= 1'b0;
            bit_cnt_r <= 4'd0;
            state_r   <= WDATA;
          end
          WDATA: begin
            if (bit_cnt_r == 4'd8) begin
              sda_oe  <= 1'b1;
              state_r <= WDATA_ACK;
            end
          end
          WDATA_ACK: begin
            sda_oe    <= 1'b0;
            bit_cnt_r <= 4'd0;
            state_r   <= WDATA;
            ptr_r     <= next_ptr(ptr_r);
            // Read-only slots still ACK, but the byte is dropped without a strobe.
            if (!is_ro_s) begin
              for (int i = 0; i < RO_BASE; i++) begin
                if (ptr_r == 7'(i)) registers_packed[8*i +: 8] <= shift_r;
              end
              wr_strobe <= 1'b1;
              wr_addr   <= ptr_r;
            end
          end
          RDATA: begin
            if (bit_cnt_r == 4'd8) begin
              sda_oe  <= 1'b0;
              ptr_r   <= next_ptr(ptr_r);
              state_r <= RDATA_ACK;
            end else begin
              sda_oe <= ~tx_r[7];
              tx_r   <= {tx_r[6:0], 1'b0};
            end
          end
          RDATA_ACK: begin
            bit_cnt_r <= 4'd0;
            if (!ack_r) begin
              state_r <= RDATA;
              sda_oe  <= ~rd_byte_s[7];
              tx_r    <= {rd_byte_s[6:0], 1'b0};
            end else begin
              state_r <= IGNORE;
              sda_oe  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
